// File: rtl/digit_serial_adder_if.sv
// Operand/result bundle for the digit-serial add/subtract unit.
// The requester drives the master side and the adder sits on the slave side.
interface digit_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, ovf
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, ovf
   );
endinterface

// File: rtl/digit_serial_adder.sv
// Multi-cycle add/subtract unit: WIDTH-bit operation, DIGIT bits per clock through a
// DIGIT-bit ripple chain, with a start/busy/done handshake.
module digit_serial_adder #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   digit_serial_adder_if.slave  bus
);
   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_adder: DIGIT must be in 1..WIDTH and divide WIDTH");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
   logic             chain_c, chain_c_msb;
   int unsigned      base;

   // One digit of the ripple chain; chain_c_msb is the carry into the digit's top bit
   always_comb begin
      base        = 32'(count_q) * DIGIT;
      dig_a       = opa_q[base +: DIGIT];
      dig_b       = opb_q[base +: DIGIT];
      dig_sum     = '0;
      chain_c     = carry_q;
      chain_c_msb = carry_q;
      for (int unsigned i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) chain_c_msb = chain_c;
         dig_sum[i] = dig_a[i] ^ dig_b[i] ^ chain_c;
         chain_c    = (dig_a[i] & dig_b[i]) | (chain_c & (dig_a[i] ^ dig_b[i]));
      end
   end

   // Next-state and registered outputs
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      count_d = count_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               opa_d   = bus.a;
               opb_d   = bus.sub ? ~bus.b : bus.b;
               carry_d = bus.sub ? ~bus.cin : bus.cin;
               count_d = '0;
               busy_d  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[base +: DIGIT] = dig_sum;
            carry_d = chain_c;
            count_d = count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
               cout_d  = chain_c;
               ovf_d   = chain_c_msb ^ chain_c;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         count_q <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         count_q <= count_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (DIGIT 1, 4, 16) run the same
// operations side by side against an arithmetic reference model.
module tb_digit_serial_adder;
   localparam int unsigned W = 16;
   localparam int unsigned WINDOW = 19;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   digit_serial_adder_if #(.WIDTH(W)) if1  ();
   digit_serial_adder_if #(.WIDTH(W)) if4  ();
   digit_serial_adder_if #(.WIDTH(W)) if16 ();

   digit_serial_adder #(.WIDTH(W), .DIGIT(1))  u_d1  (.clk(clk), .rst(rst), .bus(if1.slave));
   digit_serial_adder #(.WIDTH(W), .DIGIT(4))  u_d4  (.clk(clk), .rst(rst), .bus(if4.slave));
   digit_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (.clk(clk), .rst(rst), .bus(if16.slave));

   logic [2:0]   busy_w, done_w, cout_w, ovf_w;
   logic [W-1:0] sum_w [3];
   assign busy_w   = {if16.busy, if4.busy, if1.busy};
   assign done_w   = {if16.done, if4.done, if1.done};
   assign cout_w   = {if16.cout, if4.cout, if1.cout};
   assign ovf_w    = {if16.ovf,  if4.ovf,  if1.ovf};
   assign sum_w[0] = if1.sum;
   assign sum_w[1] = if4.sum;
   assign sum_w[2] = if16.sum;

   int checks = 0;
   int errors = 0;

   // Per-instance observations of the last operation
   int           busy_cnt [3];
   int           done_cnt [3];
   int           done_at  [3];
   logic [W-1:0] res_sum  [3];
   logic         res_cout [3];
   logic         res_ovf  [3];

   function automatic int digit_of(input int k);
      return (k == 0) ? 1 : (k == 1) ? 4 : 16;
   endfunction

   function automatic int n_of(input int k);
      return W / digit_of(k);
   endfunction

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h expected=0x%0h", nm, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic sb, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic c);
      if1.start  = s; if1.sub  = sb; if1.a  = a; if1.b  = b; if1.cin  = c;
      if4.start  = s; if4.sub  = sb; if4.a  = a; if4.b  = b; if4.cin  = c;
      if16.start = s; if16.sub = sb; if16.a = a; if16.b = b; if16.cin = c;
   endtask

   // Reference: plain integer arithmetic plus sign-based overflow rule
   task automatic model(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output logic [W-1:0] s, output logic co, output logic ov);
      logic [W:0]   full;
      logic [W-1:0] bb;
      bb   = sb ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sb ? ~c : c)};
      s    = full[W-1:0];
      co   = full[W];
      ov   = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
   endtask

   // Launch one operation and watch every instance for a fixed window
   task automatic run_op(input logic sb, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input bit stray);
      for (int k = 0; k < 3; k++) begin
         busy_cnt[k] = 0; done_cnt[k] = 0; done_at[k] = -1;
         res_sum[k] = '0; res_cout[k] = 1'b0; res_ovf[k] = 1'b0;
      end
      @(negedge clk);
      drive(1'b1, sb, a, b, c);
      for (int cyc = 1; cyc <= int'(WINDOW); cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (busy_w[k]) busy_cnt[k]++;
            if (done_w[k]) begin
               done_cnt[k]++;
               done_at[k]  = cyc;
               res_sum[k]  = sum_w[k];
               res_cout[k] = cout_w[k];
               res_ovf[k]  = ovf_w[k];
            end
         end
         if (stray && cyc == 2)      drive(1'b1, 1'b0, 16'hAAAA, 16'hAAAA, 1'b1);
         else                        drive(1'b0, 1'b0, '0, '0, 1'b0);
      end
   endtask

   task automatic check_op(input string tag, input logic [W-1:0] es, input logic eco,
                           input logic eov);
      for (int k = 0; k < 3; k++) begin
         string p;
         p = $sformatf("%s d%0d", tag, digit_of(k));
         check({p, " done_count"}, 32'(done_cnt[k]), 32'd1);
         check({p, " done_cycle"}, 32'(done_at[k]), 32'(n_of(k) + 1));
         check({p, " busy_cycles"}, 32'(busy_cnt[k]), 32'(n_of(k)));
         check({p, " sum"}, 32'(res_sum[k]), 32'(es));
         check({p, " cout"}, 32'(res_cout[k]), 32'(eco));
         check({p, " ovf"}, 32'(res_ovf[k]), 32'(eov));
      end
   endtask

   typedef struct {
      logic         sub;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{sub: 1'b0, a: 16'h1234, b: 16'h4321, cin: 1'b0, s: 16'h5555, co: 1'b0, ov: 1'b0};
      tbl[1] = '{sub: 1'b0, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, co: 1'b1, ov: 1'b0};
      tbl[2] = '{sub: 1'b0, a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, co: 1'b0, ov: 1'b1};
      tbl[3] = '{sub: 1'b1, a: 16'h0005, b: 16'h0007, cin: 1'b0, s: 16'hFFFE, co: 1'b0, ov: 1'b0};
      tbl[4] = '{sub: 1'b1, a: 16'h8000, b: 16'h0000, cin: 1'b1, s: 16'h7FFF, co: 1'b1, ov: 1'b1};
      tbl[5] = '{sub: 1'b0, a: 16'h0000, b: 16'h0000, cin: 1'b1, s: 16'h0001, co: 1'b0, ov: 1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset d%0d busy", digit_of(k)), 32'(busy_w[k]), 32'd0);
         check($sformatf("reset d%0d done", digit_of(k)), 32'(done_w[k]), 32'd0);
         check($sformatf("reset d%0d sum",  digit_of(k)), 32'(sum_w[k]),  32'd0);
         check($sformatf("reset d%0d cout", digit_of(k)), 32'(cout_w[k]), 32'd0);
         check($sformatf("reset d%0d ovf",  digit_of(k)), 32'(ovf_w[k]),  32'd0);
      end
      rst = 1'b0;

      // Directed vectors
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].sub, tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0);
         check_op($sformatf("vec%0d", i), tbl[i].s, tbl[i].co, tbl[i].ov);
      end

      // Stray start during busy/done must be ignored
      run_op(1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1);
      check_op("stray_start", 16'h0002, 1'b0, 1'b0);

      // Reset in the second RUN cycle aborts without a done pulse
      begin
         int post_done [3];
         @(negedge clk);
         drive(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0);
         @(negedge clk);
         drive(1'b0, 1'b0, '0, '0, 1'b0);
         @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         for (int k = 0; k < 3; k++) begin
            check($sformatf("midrun_rst d%0d busy", digit_of(k)), 32'(busy_w[k]), 32'd0);
            check($sformatf("midrun_rst d%0d done", digit_of(k)), 32'(done_w[k]), 32'd0);
            check($sformatf("midrun_rst d%0d sum",  digit_of(k)), 32'(sum_w[k]),  32'd0);
            post_done[k] = 0;
         end
         for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (done_w[k]) post_done[k]++;
         end
         for (int k = 0; k < 3; k++)
            check($sformatf("midrun_rst d%0d no_done", digit_of(k)), 32'(post_done[k]), 32'd0);
      end
      run_op(1'b0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
      check_op("after_rst", 16'h0100, 1'b0, 1'b0);

      // Random operations against the arithmetic model
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra, rb, es;
         logic         rs, rc, eco, eov;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         model(rs, ra, rb, rc, es, eco, eov);
         run_op(rs, ra, rb, rc, 1'b0);
         check_op($sformatf("rand%0d", i), es, eco, eov);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
